// File: rtl/mmc_cmd_framer.sv
// MMC/SD CMD-line deserializer: oversamples mmc_clk/mmc_cmd, frames 48-bit packets with CRC7 status.
// Optional macro MMC_FRAMER_CRC_DROP_EN suppresses frames that fail the CRC check.
module mmc_cmd_framer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        mmc_clk,
  input  logic        mmc_cmd,
  output logic [47:0] msg_packet,
  output logic        msg_valid,
  output logic        crc_ok,
  output logic        frame_err,
  output logic        long_busy
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r, cmd_sync_r;
  logic        clk_prev_r;
  state_t      state_r, state_nxt_s;
  logic [47:0] shift_r, shift_nxt_s, frame_s, packet_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [6:0]  crc_r, crc_nxt_s;
  logic        r2_pending_r, r2_nxt_s, r3_pending_r, r3_nxt_s;
  logic        sample_s, bit_s, host_s, crc_good_s;
  logic [5:0]  idx_s;
  logic        valid_nxt_s, crc_ok_nxt_s, ferr_nxt_s, busy_nxt_s;

  assign sample_s = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
  assign bit_s    = cmd_sync_r[SYNC_STAGES-1];

  // Synchronize the target pins and remember the previous clock level for edge detection
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      clk_sync_r <= '0;
      cmd_sync_r <= '1;
      clk_prev_r <= 1'b0;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], mmc_clk};
      cmd_sync_r <= {cmd_sync_r[SYNC_STAGES-2:0], mmc_cmd};
      clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  // Framing state machine: next state, datapath and output values
  always_comb begin
    frame_s      = {shift_r[46:0], bit_s};
    host_s       = frame_s[46];
    idx_s        = frame_s[45:40];
    // A response answering CMD1/CMD41 carries no valid CRC, so it is exempt.
    crc_good_s   = (crc_r == frame_s[7:1]) || (r3_pending_r && !host_s);
    state_nxt_s  = state_r;
    shift_nxt_s  = shift_r;
    cnt_nxt_s    = cnt_r;
    crc_nxt_s    = crc_r;
    r2_nxt_s     = r2_pending_r;
    r3_nxt_s     = r3_pending_r;
    packet_nxt_s = msg_packet;
    crc_ok_nxt_s = crc_ok;
    valid_nxt_s  = 1'b0;
    ferr_nxt_s   = 1'b0;
    if (sample_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!bit_s) begin
            state_nxt_s = ST_SHIFT;
            shift_nxt_s = 48'd0;
            cnt_nxt_s   = 8'd1;
            crc_nxt_s   = 7'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          shift_nxt_s = frame_s;
          if (cnt_r <= 8'd39) begin
            crc_nxt_s = crc7_step(crc_r, bit_s);
          end else begin
            crc_nxt_s = crc_r;
          end
          if ((cnt_r == 8'd1) && r2_pending_r && !bit_s) begin
            state_nxt_s = ST_LONG;
            cnt_nxt_s   = 8'd2;
            r2_nxt_s    = 1'b0;
          end else if (cnt_r == 8'd47) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 8'd0;
            r3_nxt_s    = host_s && ((idx_s == 6'd1) || (idx_s == 6'd41));
            if (host_s) begin
              r2_nxt_s = (idx_s == 6'd2) || (idx_s == 6'd9) || (idx_s == 6'd10);
            end else begin
              r2_nxt_s = r2_pending_r;
            end
            if (!bit_s) begin
              ferr_nxt_s = 1'b1;
            end else begin
`ifdef MMC_FRAMER_CRC_DROP_EN
              if (crc_good_s) begin
                packet_nxt_s = frame_s;
                valid_nxt_s  = 1'b1;
                crc_ok_nxt_s = 1'b1;
              end else begin
                packet_nxt_s = msg_packet;
              end
`else
              packet_nxt_s = frame_s;
              valid_nxt_s  = 1'b1;
              crc_ok_nxt_s = crc_good_s;
`endif
            end
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end
        ST_LONG: begin
          if (cnt_r == 8'd135) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 8'd0;
          end else begin
            cnt_nxt_s = cnt_r + 8'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    busy_nxt_s = (state_nxt_s == ST_LONG);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      shift_r      <= 48'd0;
      cnt_r        <= 8'd0;
      crc_r        <= 7'd0;
      r2_pending_r <= 1'b0;
      r3_pending_r <= 1'b0;
      msg_packet   <= 48'd0;
      msg_valid    <= 1'b0;
      crc_ok       <= 1'b0;
      frame_err    <= 1'b0;
      long_busy    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      shift_r      <= shift_nxt_s;
      cnt_r        <= cnt_nxt_s;
      crc_r        <= crc_nxt_s;
      r2_pending_r <= r2_nxt_s;
      r3_pending_r <= r3_nxt_s;
      msg_packet   <= packet_nxt_s;
      msg_valid    <= valid_nxt_s;
      crc_ok       <= crc_ok_nxt_s;
      frame_err    <= ferr_nxt_s;
      long_busy    <= busy_nxt_s;
    end
  end
endmodule

// File: tb/tb_mmc_cmd_framer.sv
// Scoreboard bench for mmc_cmd_framer: serial CMD stimulus at mmc_clk = clk/4, expected frames queued on send.
module tb_mmc_cmd_framer;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        mmc_clk = 1'b0;
  logic        mmc_cmd = 1'b1;
  logic [47:0] msg_packet;
  logic        msg_valid, crc_ok, frame_err, long_busy;

  typedef struct packed {
    logic [47:0] pkt;
    logic        ok;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   ferr_seen = 0;
  int   lb_cycles = 0;
  logic valid_prev = 1'b0;

  localparam logic [47:0] CMD0   = 48'h400000000095;
  localparam logic [47:0] CMD8   = 48'h48000001AA87;
  localparam logic [47:0] CMD8_B = 48'h48000001AA89;
  localparam logic [47:0] CMD2   = 48'h42000000004D;
  localparam logic [47:0] CMD13  = 48'h4D000100007F;
  localparam logic [47:0] R3     = 48'h3F80FF8000FF;
  localparam logic [47:0] BADEND = 48'h400000000094;

  always #5 clk = ~clk;

  mmc_cmd_framer #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .mmc_clk    (mmc_clk),
    .mmc_cmd    (mmc_cmd),
    .msg_packet (msg_packet),
    .msg_valid  (msg_valid),
    .crc_ok     (crc_ok),
    .frame_err  (frame_err),
    .long_busy  (long_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [6:0] r;
    r = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      if (d[i] ^ r[6]) r = (r << 1) ^ 7'h09;
      else             r = r << 1;
    end
    return r;
  endfunction

  function automatic logic crc_matches(input logic [47:0] f);
    return ref_crc7(f[47:8]) == f[7:1];
  endfunction

  task automatic send_bits(input logic [135:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mmc_cmd = v[i];
      #20 mmc_clk = 1'b1;
      #20 mmc_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    send_bits({88'd0, f}, 48);
  endtask

  task automatic idle_bits(input int n);
    send_bits({136{1'b1}}, n);
  endtask

  task automatic expect_frame(input logic [47:0] f, input logic ok);
    exp_t e;
    e.pkt = f;
    e.ok  = ok;
    sb_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_packet"}, 64'(msg_packet), 64'd0);
    check_eq({tag, "_valid"}, 64'(msg_valid), 64'd0);
    check_eq({tag, "_crc_ok"}, 64'(crc_ok), 64'd0);
    check_eq({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check_eq({tag, "_long_busy"}, 64'(long_busy), 64'd0);
  endtask

  // Output monitor: compare every emitted frame against the scoreboard head
  always @(negedge clk) begin
    if (!reset_i) begin
      if (msg_valid) begin
        check_eq("no_b2b_valid", 64'(valid_prev), 64'd0);
        check_eq("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check_eq("packet", 64'(msg_packet), 64'(mon_e.pkt));
          check_eq("crc_ok", 64'(crc_ok), 64'(mon_e.ok));
        end
      end
      if (frame_err) ferr_seen++;
      if (long_busy) lb_cycles++;
    end
    valid_prev <= msg_valid;
  end

  initial begin
    logic [47:0] cmd1;
    logic [47:0] partial;
    cmd1 = {8'h41, 32'h40FF8000, 8'h00};
    cmd1[7:0] = {ref_crc7(cmd1[47:8]), 1'b1};

    #30;
    check_all_zero("reset");
    #70 reset_i = 1'b0;
    idle_bits(3);

    // CMD0
    expect_frame(CMD0, 1'b1);
    send_frame(CMD0);
    idle_bits(2);

    // CMD8 followed back-to-back by a corrupted copy
    expect_frame(CMD8, 1'b1);
`ifndef MMC_FRAMER_CRC_DROP_EN
    expect_frame(CMD8_B, 1'b0);
`endif
    send_frame(CMD8);
    send_frame(CMD8_B);
    idle_bits(2);
`ifdef MMC_FRAMER_CRC_DROP_EN
    check_eq("drop_keeps_cmd8", 64'(msg_packet), 64'(CMD8));
`else
    check_eq("last_is_bad_cmd8", 64'(msg_packet), 64'(CMD8_B));
`endif

    // CMD2, 136-bit R2 response to be skipped, then CMD13
    expect_frame(CMD2, 1'b1);
    send_frame(CMD2);
    idle_bits(2);
    send_bits({8'h3F, 64'h0123456789ABCDEF, 56'h00FF00FF00FF00, 8'h81}, 136);
    idle_bits(2);
    check_eq("long_busy_after_r2", 64'(long_busy), 64'd0);
    expect_frame(CMD13, crc_matches(CMD13));
    send_frame(CMD13);
    idle_bits(2);
    check_eq("after_r2_packet", 64'(msg_packet), 64'(CMD13));

    // CMD1 then its CRC-less R3 response
    expect_frame(cmd1, 1'b1);
    send_frame(cmd1);
    idle_bits(2);
    expect_frame(R3, 1'b1);
    send_frame(R3);
    idle_bits(2);

    // Frame with end bit 0: frame_err only, packet unchanged
    send_frame(BADEND);
    idle_bits(2);
    check_eq("frame_err_count", 64'(ferr_seen), 64'd1);
    check_eq("badend_packet_kept", 64'(msg_packet), 64'(R3));

    // Reset in the middle of a frame, then a clean CMD0
    partial = CMD0 >> 28;
    send_bits({88'd0, partial}, 20);
    #10 reset_i = 1'b1;
    #20;
    check_all_zero("mid_reset");
    #20 reset_i = 1'b0;
    idle_bits(3);
    expect_frame(CMD0, 1'b1);
    send_frame(CMD0);
    idle_bits(3);
    #100;

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    check_eq("frame_err_total", 64'(ferr_seen), 64'd1);
    check_eq("long_busy_len_ok", 64'((lb_cycles >= 134 * 4) && (lb_cycles <= 136 * 4)), 64'd1);
    check_eq("final_packet", 64'(msg_packet), 64'(CMD0));
    check_eq("final_crc_ok", 64'(crc_ok), 64'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
